alu_branch_unit: RTL and testbench

- Execute-stage datapath block of the multi-cycle MIPS core; merges three functions:
  - ALU operand-A source select: register value or shift amount.
  - 32-bit ALU with HI/LO multiply results.
  - Branch target resolver.
- Sequenced by the control unit's enable/done handshakes. Each function registers its result one clock after its enable is seen.

---
 rtl/alu_branch_unit_if.sv | 38 +++
 rtl/alu_branch_unit.sv | 126 ++++++++++++
 tb/tb_alu_branch_unit.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_branch_unit_if.sv
// Execute-stage bus between the control/datapath side and alu_branch_unit.
// Carries the ALU operands, results and handshakes plus the branch resolver signals.
// master drives operands and enables; slave returns results and done flags.
interface alu_branch_unit_if #(parameter int WIDTH = 32);
    logic             alu_en;
    logic [3:0]       alu_control;
    logic [WIDTH-1:0] read_data1;
    logic [4:0]       shamt;
    logic             select_shamt;
    logic [WIDTH-1:0] alu_srcB;
    logic [WIDTH-1:0] alu_srcA;
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             overflow;
    logic             alu_zero;
    logic             alu_done;
    logic             branch_en;
    logic             branch;
    logic [WIDTH-1:0] imm;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_out;
    logic             branch_done;

    modport master (
        output alu_en, alu_control, read_data1, shamt, select_shamt, alu_srcB,
        output branch_en, branch, imm, pc,
        input  alu_srcA, alu_result, hi, lo, overflow, alu_zero, alu_done,
        input  pc_out, branch_done
    );

    modport slave (
        input  alu_en, alu_control, read_data1, shamt, select_shamt, alu_srcB,
        input  branch_en, branch, imm, pc,
        output alu_srcA, alu_result, hi, lo, overflow, alu_zero, alu_done,
        output pc_out, branch_done
    );
endinterface

// File: rtl/alu_branch_unit.sv
// Execute stage: operand-A select, 32-bit ALU with HI/LO multiply, branch target resolver.
// Latency: results and done flags register one clock after the enable is sampled.
// No backpressure: the control unit holds each enable until it sees the matching done flag.
module alu_branch_unit #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    alu_branch_unit_if.slave bus
);

    logic [WIDTH-1:0]   src_a;
    logic [WIDTH-1:0]   src_b;
    logic [WIDTH-1:0]   sum;
    logic [WIDTH-1:0]   diff;
    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_u;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   res_nxt;
    logic               ovf_nxt;
    logic               mul_op;

    logic [WIDTH-1:0]   alu_result_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               overflow_q;
    logic               alu_zero_q;
    logic               alu_done_q;
    logic [WIDTH-1:0]   pc_out_q;
    logic               branch_done_q;

    assign src_a  = bus.select_shamt ? {{(WIDTH-5){1'b0}}, bus.shamt} : bus.read_data1;
    assign src_b  = bus.alu_srcB;
    assign sum    = src_a + src_b;
    assign diff   = src_a - src_b;
    // Sign- or zero-extend to double width so the low 2*WIDTH bits are the exact product.
    assign prod_s = {{WIDTH{src_a[WIDTH-1]}}, src_a} * {{WIDTH{src_b[WIDTH-1]}}, src_b};
    assign prod_u = {{WIDTH{1'b0}}, src_a} * {{WIDTH{1'b0}}, src_b};

    // Decode the opcode into the next result, overflow flag and multiply product.
    always_comb begin
        res_nxt = '0;
        ovf_nxt = 1'b0;
        mul_op  = 1'b0;
        prod    = prod_s;
        case (bus.alu_control)
            4'b0000: begin
                res_nxt = sum;
                ovf_nxt = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (sum[WIDTH-1] != src_a[WIDTH-1]);
            end
            4'b0001: res_nxt = sum;
            4'b0010: begin
                res_nxt = diff;
                ovf_nxt = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (diff[WIDTH-1] != src_a[WIDTH-1]);
            end
            4'b0011: res_nxt = diff;
            4'b0100: res_nxt = src_a & src_b;
            4'b0101: res_nxt = src_a | src_b;
            4'b0110: res_nxt = src_a ^ src_b;
            4'b0111: res_nxt = ~(src_a | src_b);
            4'b1000: res_nxt = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            4'b1001: res_nxt = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
            4'b1010: res_nxt = src_b << src_a[4:0];
            4'b1011: res_nxt = src_b >> src_a[4:0];
            4'b1100: res_nxt = $signed(src_b) >>> src_a[4:0];
            4'b1101: begin
                mul_op  = 1'b1;
                prod    = prod_s;
                res_nxt = prod_s[WIDTH-1:0];
            end
            4'b1110: begin
                mul_op  = 1'b1;
                prod    = prod_u;
                res_nxt = prod_u[WIDTH-1:0];
            end
            4'b1111: res_nxt = src_b << 16;
        endcase
    end

    // ALU result registers; they hold when alu_en drops so later stages can still read them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_result_q <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
            overflow_q   <= 1'b0;
            alu_zero_q   <= 1'b0;
            alu_done_q   <= 1'b0;
        end else if (bus.alu_en) begin
            alu_result_q <= res_nxt;
            overflow_q   <= ovf_nxt;
            alu_zero_q   <= (res_nxt == '0);
            alu_done_q   <= 1'b1;
            if (mul_op) begin
                hi_q <= prod[2*WIDTH-1:WIDTH];
                lo_q <= prod[WIDTH-1:0];
            end
        end else begin
            alu_done_q   <= 1'b0;
        end
    end

    // Branch resolver; reads the registered alu_zero, i.e. the value before this edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_out_q      <= '0;
            branch_done_q <= 1'b0;
        end else if (bus.branch_en) begin
            pc_out_q      <= (bus.branch && alu_zero_q) ? bus.pc + bus.imm : bus.pc;
            branch_done_q <= 1'b1;
        end else begin
            branch_done_q <= 1'b0;
        end
    end

    assign bus.alu_srcA    = src_a;
    assign bus.alu_result  = alu_result_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.overflow    = overflow_q;
    assign bus.alu_zero    = alu_zero_q;
    assign bus.alu_done    = alu_done_q;
    assign bus.pc_out      = pc_out_q;
    assign bus.branch_done = branch_done_q;

endmodule

// File: tb/tb_alu_branch_unit.sv
// Bench for alu_branch_unit: directed cases plus randomized operations against a reference model.
// The model tracks every registered output and is updated from the operation rules each edge.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled at the same offset.
module tb_alu_branch_unit;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    alu_branch_unit_if #(.WIDTH(32)) bus ();

    alu_branch_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state for every registered output.
    logic [31:0] m_res, m_hi, m_lo, m_pc;
    logic        m_ovf, m_zero, m_alu_done, m_br_done;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_res = '0; m_hi = '0; m_lo = '0; m_pc = '0;
        m_ovf = 1'b0; m_zero = 1'b0; m_alu_done = 1'b0; m_br_done = 1'b0;
    endtask

    // Operation rules expressed with plain 64-bit arithmetic.
    task automatic model_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, s;
        logic [63:0] pu;
        int          amt;
        sa    = longint'($signed(a));
        sb    = longint'($signed(b));
        amt   = int'(a % 32);
        m_ovf = 1'b0;
        case (op)
            4'h0: begin s = sa + sb; m_res = s[31:0]; m_ovf = (s != longint'($signed(m_res))); end
            4'h1: m_res = a + b;
            4'h2: begin s = sa - sb; m_res = s[31:0]; m_ovf = (s != longint'($signed(m_res))); end
            4'h3: m_res = a - b;
            4'h4: m_res = a & b;
            4'h5: m_res = a | b;
            4'h6: m_res = a ^ b;
            4'h7: m_res = ~(a | b);
            4'h8: m_res = (sa < sb) ? 32'd1 : 32'd0;
            4'h9: m_res = (a < b) ? 32'd1 : 32'd0;
            4'hA: m_res = b << amt;
            4'hB: m_res = b >> amt;
            4'hC: begin s = sb >>> amt; m_res = s[31:0]; end
            4'hD: begin s = sa * sb; m_hi = s[63:32]; m_lo = s[31:0]; m_res = m_lo; end
            4'hE: begin pu = {32'b0, a} * {32'b0, b}; m_hi = pu[63:32]; m_lo = pu[31:0]; m_res = m_lo; end
            default: begin m_res = b << 16; end
        endcase
        m_zero     = (m_res == 32'd0);
        m_alu_done = 1'b1;
    endtask

    task automatic check_outputs(input string pfx);
        check({pfx, "_result"}, bus.alu_result, m_res);
        check({pfx, "_hi"}, bus.hi, m_hi);
        check({pfx, "_lo"}, bus.lo, m_lo);
        check({pfx, "_ovf"}, 32'(bus.overflow), 32'(m_ovf));
        check({pfx, "_zero"}, 32'(bus.alu_zero), 32'(m_zero));
        check({pfx, "_alu_done"}, 32'(bus.alu_done), 32'(m_alu_done));
        check({pfx, "_pc_out"}, bus.pc_out, m_pc);
        check({pfx, "_br_done"}, 32'(bus.branch_done), 32'(m_br_done));
    endtask

    // One clock: check operand A, predict from pre-edge model state, then compare after the edge.
    task automatic step(input string pfx);
        logic [31:0] a_exp;
        #1;
        a_exp = bus.select_shamt ? {27'b0, bus.shamt} : bus.read_data1;
        check({pfx, "_srcA"}, bus.alu_srcA, a_exp);
        if (bus.branch_en) begin
            m_pc      = (bus.branch && m_zero) ? bus.pc + bus.imm : bus.pc;
            m_br_done = 1'b1;
        end else begin
            m_br_done = 1'b0;
        end
        if (bus.alu_en) model_alu(bus.alu_control, a_exp, bus.alu_srcB);
        else            m_alu_done = 1'b0;
        @(posedge clk);
        #1;
        check_outputs(pfx);
    endtask

    task automatic drive_alu(input logic [3:0] op, input logic [31:0] rd1, input logic [4:0] sh,
                             input logic sel, input logic [31:0] b);
        bus.alu_en       = 1'b1;
        bus.alu_control  = op;
        bus.read_data1   = rd1;
        bus.shamt        = sh;
        bus.select_shamt = sel;
        bus.alu_srcB     = b;
    endtask

    task automatic drive_branch(input logic en, input logic br, input logic [31:0] p, input logic [31:0] im);
        bus.branch_en = en;
        bus.branch    = br;
        bus.pc        = p;
        bus.imm       = im;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom % 6)
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        drive_alu(4'h0, 32'h0, 5'd0, 1'b0, 32'h0);
        bus.alu_en = 1'b0;
        drive_branch(1'b0, 1'b0, 32'h0, 32'h0);
        #1 rst = 1'b1;
        #1;
        model_reset();
        check_outputs("reset");
        #2 rst = 1'b0;

        // ADD overflow, then drop enable and confirm the result holds.
        drive_alu(4'h0, 32'h7FFF_FFFF, 5'd0, 1'b0, 32'h1);
        step("add");
        check("add_res_const", bus.alu_result, 32'h8000_0000);
        check("add_ovf_const", 32'(bus.overflow), 32'd1);
        bus.alu_en = 1'b0;
        step("add_drop");
        check("add_hold_const", bus.alu_result, 32'h8000_0000);
        drive_alu(4'h1, 32'h7FFF_FFFF, 5'd0, 1'b0, 32'h1);
        step("addu");
        check("addu_ovf_const", 32'(bus.overflow), 32'd0);

        drive_alu(4'h2, 32'd5, 5'd0, 1'b0, 32'd5);
        step("sub_zero");
        check("sub_zero_const", 32'(bus.alu_zero), 32'd1);
        drive_alu(4'h8, 32'hFFFF_FFFF, 5'd0, 1'b0, 32'd1);
        step("slt");
        check("slt_const", bus.alu_result, 32'd1);
        drive_alu(4'h9, 32'hFFFF_FFFF, 5'd0, 1'b0, 32'd1);
        step("sltu");
        check("sltu_const", bus.alu_result, 32'd0);

        drive_alu(4'hC, 32'hDEAD_BEEF, 5'd4, 1'b1, 32'h8000_0000);
        step("sra");
        check("sra_srcA_const", bus.alu_srcA, 32'd4);
        check("sra_const", bus.alu_result, 32'hF800_0000);
        drive_alu(4'hB, 32'hDEAD_BEEF, 5'd4, 1'b1, 32'h8000_0000);
        step("srl");
        check("srl_const", bus.alu_result, 32'h0800_0000);

        drive_alu(4'hD, 32'hFFFF_FFFE, 5'd0, 1'b0, 32'd3);
        step("mult");
        check("mult_hi_const", bus.hi, 32'hFFFF_FFFF);
        check("mult_lo_const", bus.lo, 32'hFFFF_FFFA);
        drive_alu(4'hE, 32'hFFFF_FFFE, 5'd0, 1'b0, 32'd3);
        step("multu");
        check("multu_hi_const", bus.hi, 32'h0000_0002);
        drive_alu(4'h0, 32'hFFFF_FFFE, 5'd0, 1'b0, 32'd3);
        step("add_after_mul");
        check("hi_held_const", bus.hi, 32'h0000_0002);
        check("lo_held_const", bus.lo, 32'hFFFF_FFFA);

        // Branch taken with negative offset, not taken, and unconditional fall-through.
        drive_alu(4'h2, 32'd5, 5'd0, 1'b0, 32'd5);
        step("br_setup");
        bus.alu_en = 1'b0;
        drive_branch(1'b1, 1'b1, 32'd10, 32'hFFFF_FFFC);
        step("br_taken");
        check("br_taken_const", bus.pc_out, 32'd6);
        drive_alu(4'h0, 32'd1, 5'd0, 1'b0, 32'd1);
        drive_branch(1'b0, 1'b1, 32'd10, 32'hFFFF_FFFC);
        step("br_setup2");
        bus.alu_en = 1'b0;
        drive_branch(1'b1, 1'b1, 32'd10, 32'hFFFF_FFFC);
        step("br_not_taken");
        check("br_not_taken_const", bus.pc_out, 32'd10);
        drive_alu(4'h3, 32'd7, 5'd0, 1'b0, 32'd7);
        drive_branch(1'b0, 1'b0, 32'd20, 32'd4);
        step("br_setup3");
        bus.alu_en = 1'b0;
        drive_branch(1'b1, 1'b0, 32'd20, 32'd4);
        step("br_uncond");
        check("br_uncond_const", bus.pc_out, 32'd20);

        // Both enables together: branch must use the zero flag from before the edge (still 1).
        drive_alu(4'h0, 32'd2, 5'd0, 1'b0, 32'd2);
        drive_branch(1'b1, 1'b1, 32'd100, 32'd8);
        step("both_en");
        check("both_en_const", bus.pc_out, 32'd108);

        // Reset in the middle of a held handshake, then restart.
        step("pre_reset");
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_outputs("mid_reset");
        #1 rst = 1'b0;
        step("restart");

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            bus.alu_en       = ($urandom % 4) != 0;
            bus.alu_control  = 4'($urandom);
            bus.read_data1   = pick();
            bus.shamt        = 5'($urandom);
            bus.select_shamt = ($urandom % 3) == 0;
            bus.alu_srcB     = (($urandom % 5) == 0) ? bus.read_data1 : pick();
            bus.branch_en    = ($urandom % 2) != 0;
            bus.branch       = ($urandom % 4) != 0;
            bus.pc           = pick();
            bus.imm          = (($urandom % 2) != 0) ? 32'($signed(8'($urandom))) : pick();
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
